// File: rtl/celem_checker.sv
// Protocol checker for a two-input Muller C-element: tracks the expected output,
// counts correct firings and flags timeout, spurious and withdrawn-input violations.
module celem_checker #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             in0,
  input  logic             in1,
  input  logic             out,
  output logic             target,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] fires,
  output logic [CNT_W-1:0] errors,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    DIS    = 2'b00,
    STABLE = 2'b01,
    PEND   = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic       target_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       agree;
  logic       fire;
  logic       err;
  logic [1:0] code;

  assign agree     = (in0 == in1);
  assign fsm_state = state;

  // While pending, the value being waited for is always ~target.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    wait_nxt   = wait_cnt;
    fire       = 1'b0;
    err        = 1'b0;
    code       = 2'd0;
    if (!en) begin
      state_nxt = DIS;
      wait_nxt  = 8'd0;
    end else begin
      case (state)
        DIS: begin
          target_nxt = out;
          state_nxt  = STABLE;
          wait_nxt   = 8'd0;
        end
        STABLE: begin
          if (agree && (in0 != target)) begin
            state_nxt = PEND;
            wait_nxt  = 8'd1;
          end else if (out != target) begin
            err        = 1'b1;
            code       = 2'd2;
            target_nxt = out;
          end
        end
        PEND: begin
          if (out != target) begin
            fire       = 1'b1;
            target_nxt = ~target;
            state_nxt  = STABLE;
            wait_nxt   = 8'd0;
          end else if (!agree || (in0 == target)) begin
            err       = 1'b1;
            code      = 2'd3;
            state_nxt = STABLE;
            wait_nxt  = 8'd0;
          end else if (wait_cnt >= TIMEOUT_C) begin
            err        = 1'b1;
            code       = 2'd1;
            target_nxt = ~target;
            state_nxt  = STABLE;
            wait_nxt   = 8'd0;
          end else begin
            wait_nxt = wait_cnt + 8'd1;
          end
        end
        default: begin
          state_nxt = DIS;
          wait_nxt  = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= DIS;
      target     <= 1'b0;
      wait_cnt   <= 8'd0;
      fires      <= '0;
      errors     <= '0;
      err_pulse  <= 1'b0;
      err_code   <= 2'd0;
      err_sticky <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      wait_cnt  <= wait_nxt;
      err_pulse <= err;
      if (clear) begin
        fires      <= '0;
        errors     <= '0;
        err_code   <= 2'd0;
        err_sticky <= 1'b0;
      end else begin
        if (fire && (fires != '1)) fires <= fires + CNT_W'(1);
        if (err) begin
          if (errors != '1) errors <= errors + CNT_W'(1);
          err_code   <= code;
          err_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_celem_checker.sv
// Directed bench for celem_checker; a second CNT_W=4 instance shares the stimulus
// to exercise counter saturation.
module tb_celem_checker;
   logic        clk = 1'b0;
   logic        rst, en, clear, in0, in1, out;
   logic        target, err_pulse, err_sticky;
   logic [1:0]  fsm_state, err_code;
   logic [15:0] fires, errors;
   logic        t4, ep4, es4;
   logic [1:0]  fs4, ec4;
   logic [3:0]  fires4, errors4;
   int          checks = 0;
   int          failures = 0;
   logic [3:0]  pat0, pat1, pato;

   always #5 clk = ~clk;

   celem_checker dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .in0(in0), .in1(in1), .out(out),
      .target(target), .fsm_state(fsm_state), .fires(fires), .errors(errors),
      .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky)
   );

   celem_checker #(.TIMEOUT(8), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .in0(in0), .in1(in1), .out(out),
      .target(t4), .fsm_state(fs4), .fires(fires4), .errors(errors4),
      .err_pulse(ep4), .err_code(ec4), .err_sticky(es4)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic a, input logic b, input logic o);
      in0 = a;
      in1 = b;
      out = o;
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; clear = 1'b0;
      drive(0, 0, 0);
      #2 rst = 1'b1;
      #1;
      chk("rst_state", fsm_state, 2'd0);
      chk("rst_target", target, 1'b0);
      chk("rst_fires", fires, 16'd0);
      chk("rst_errors", errors, 16'd0);
      chk("rst_pulse", err_pulse, 1'b0);
      chk("rst_code", err_code, 2'd0);
      chk("rst_sticky", err_sticky, 1'b0);

      @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
      tick();
      chk("en_state", fsm_state, 2'd1);
      chk("en_target", target, 1'b0);

      // Phase-shifted inputs: in0 leads in1 by one cycle, out follows one cycle after agreement.
      pat0 = 4'b0011;
      pat1 = 4'b0110;
      pato = 4'b1100;
      for (int p = 0; p < 10; p++) begin
         for (int c = 0; c < 4; c++) begin
            drive(pat0[c], pat1[c], pato[c]);
            tick();
            if (p == 0 && c == 1) begin
               chk("phase_pend", fsm_state, 2'd2);
            end
         end
      end
      drive(1, 0, 0);
      tick();
      chk("phase_fires", fires, 16'd20);
      chk("phase_errors", errors, 16'd0);
      chk("phase_sticky", err_sticky, 1'b0);
      chk("phase_state", fsm_state, 2'd1);
      chk("phase_target", target, 1'b0);
      chk("sat_fires4", fires4, 4'd15);
      chk("sat_errors4", errors4, 4'd0);

      // Clear lands on the same edge as a firing.
      drive(1, 1, 0);
      tick();
      chk("clr_pend", fsm_state, 2'd2);
      out   = 1'b1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_fires", fires, 16'd0);
      chk("clr_target", target, 1'b1);
      chk("clr_state", fsm_state, 2'd1);

      // Return target to 0, then hold out low while the inputs agree on 1.
      drive(0, 0, 1);
      tick();
      out = 1'b0;
      tick();
      chk("to_prep_target", target, 1'b0);
      drive(1, 1, 0);
      tick();
      for (int i = 0; i < 7; i++) tick();
      chk("to_early_pulse", err_pulse, 1'b0);
      chk("to_early_state", fsm_state, 2'd2);
      tick();
      chk("to_pulse", err_pulse, 1'b1);
      chk("to_code", err_code, 2'd1);
      chk("to_errors", errors, 16'd1);
      chk("to_target", target, 1'b1);
      chk("to_sticky", err_sticky, 1'b1);
      chk("to_state", fsm_state, 2'd1);
      out = 1'b1;
      tick();
      chk("to_pulse_end", err_pulse, 1'b0);
      chk("to_errors_hold", errors, 16'd1);

      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr2_errors", errors, 16'd0);
      chk("clr2_code", err_code, 2'd0);
      chk("clr2_sticky", err_sticky, 1'b0);
      chk("clr2_target", target, 1'b1);
      chk("clr2_state", fsm_state, 2'd1);

      // Spurious output change with target 0 and disagreeing inputs.
      drive(0, 0, 1);
      tick();
      out = 1'b0;
      tick();
      chk("sp_prep_fires", fires, 16'd1);
      drive(1, 0, 1);
      tick();
      chk("sp_pulse", err_pulse, 1'b1);
      chk("sp_code", err_code, 2'd2);
      chk("sp_errors", errors, 16'd1);
      chk("sp_target", target, 1'b1);
      tick();
      chk("sp_quiet", err_pulse, 1'b0);

      // Inputs agree on 1 for two cycles, then in1 withdraws before out moves.
      drive(0, 0, 1);
      tick();
      out = 1'b0;
      tick();
      chk("wd_prep_fires", fires, 16'd2);
      drive(1, 1, 0);
      tick();
      tick();
      chk("wd_wait_state", fsm_state, 2'd2);
      in1 = 1'b0;
      tick();
      chk("wd_code", err_code, 2'd3);
      chk("wd_target", target, 1'b0);
      chk("wd_fires", fires, 16'd2);
      chk("wd_errors", errors, 16'd2);
      chk("wd_pulse", err_pulse, 1'b1);
      chk("wd_state", fsm_state, 2'd1);

      // Reset in the middle of a pending check.
      drive(1, 1, 0);
      tick();
      chk("rp_pend", fsm_state, 2'd2);
      rst = 1'b1;
      #1;
      chk("rp_state", fsm_state, 2'd0);
      chk("rp_fires", fires, 16'd0);
      chk("rp_errors", errors, 16'd0);
      chk("rp_target", target, 1'b0);
      chk("rp_code", err_code, 2'd0);
      chk("rp_sticky", err_sticky, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rp_rel_state", fsm_state, 2'd1);
      chk("rp_rel_errors", errors, 16'd0);
      chk("rp_rel_pulse", err_pulse, 1'b0);

      // Log one error, enter PEND, then drop en.
      drive(1, 0, 1);
      tick();
      chk("en_sp_errors", errors, 16'd1);
      drive(0, 0, 1);
      tick();
      chk("en_pend", fsm_state, 2'd2);
      en = 1'b0;
      tick();
      chk("en_dis_state", fsm_state, 2'd0);
      chk("en_dis_errors", errors, 16'd1);
      chk("en_dis_pulse", err_pulse, 1'b0);
      chk("en_dis_target", target, 1'b1);
      drive(1, 0, 0);
      tick();
      chk("en_dis_hold", fsm_state, 2'd0);
      chk("en_dis_hold_err", errors, 16'd1);
      en = 1'b1;
      tick();
      chk("en_back_state", fsm_state, 2'd1);
      chk("en_back_target", target, 1'b0);
      chk("en_back_errors", errors, 16'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
